hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL provide the following ports:
  clk  in  1  rising-edge clock.
  rst  in  1  synchronous reset, active-low (0 = reset).
  fwd_en  in  1  forwarding unit enabled.
  id_src1  in  5  ID-stage source register 1.
  id_src2  in  5  ID-stage source register 2.
  id_two_src  in  1  ID instruction reads id_src2 as a register.
  exe_dest  in  5  EXE-stage destination.
  exe_wb_en  in  1  EXE-stage writeback enable.
  exe_mem_r_en  in  1  EXE-stage load.
  mem_dest  in  5  MEM-stage destination.
  mem_wb_en  in  1  MEM-stage writeback enable.
  branch_taken  in  1  EXE-stage branch resolved taken (1-cycle pulse).
  mem_busy  in  1  memory controller has not completed the MEM access.
  stall  out  1  hold PC and IF/ID; hold ID/EX.
  superStall  out  1  freeze every pipeline register.
  flush  out  1  clear IF/ID and ID/EX.
  stall_cnt  out  16  count of stalled cycles, saturating.
  wd_err  out  1  sticky memory-watchdog error.

Function
REQ-002 SHALL implement FSM states RUN, MEMWAIT and FLUSH; state register updates on the rising edge of clk.
REQ-003 A hazard on register r SHALL require r != 0.
REQ-004 Hazard match SHALL be computed as: (id_src1 == d) or (id_two_src and id_src2 == d).
REQ-005 When fwd_en=1, raw_haz SHALL equal exe_mem_r_en AND a match on d=exe_dest.
REQ-006 When fwd_en=0, raw_haz SHALL equal (exe_wb_en AND a match on exe_dest) OR (mem_wb_en AND a match on mem_dest).
REQ-007 In RUN, outputs SHALL be combinational:
  - superStall = mem_busy.
  - flush = branch_taken AND NOT mem_busy.
  - stall = raw_haz AND NOT branch_taken AND NOT mem_busy.
REQ-008 RUN -> MEMWAIT when mem_busy=1.
  - If branch_taken=1 in the same cycle, set flush_pend.
REQ-009 RUN -> FLUSH when branch_taken=1 and mem_busy=0.
REQ-010 In MEMWAIT:
  - superStall=1, stall=0, flush=0.
  - branch_taken=1 sets flush_pend.
  - On mem_busy=0, go to FLUSH if flush_pend=1, else to RUN.
REQ-011 FLUSH SHALL assert flush=1 for exactly one cycle, with stall=0 and superStall=0.
  - FLUSH clears flush_pend and returns to RUN.
  - mem_busy=1 during FLUSH SHALL take priority: superStall=1, flush=0, flush_pend set, go to MEMWAIT.
REQ-012 Output priority SHALL be superStall > flush > stall.
  - No two of these outputs SHALL be asserted in the same cycle.
REQ-013 stall_cnt SHALL increment by 1 each cycle in which stall or superStall is 1.
  - stall_cnt SHALL saturate at 16'hFFFF and not wrap.
REQ-014 An 8-bit watchdog counter SHALL:
  - increment each MEMWAIT cycle;
  - clear on leaving MEMWAIT.
REQ-015 When the watchdog counter reaches 255, wd_err SHALL set and remain set until reset.
  - The watchdog counter SHALL hold at 255.
  - FSM behaviour is unchanged by wd_err.
REQ-016 Total latency from any input to stall, superStall or flush SHALL be 0 cycles (combinational in the current state).

Reset
REQ-017 While rst=0 at a clock edge:
  - state SHALL become RUN.
  - flush_pend, the watchdog counter, stall_cnt and wd_err SHALL become 0.
REQ-018 While rst=0, stall, superStall and flush SHALL be forced to 0 combinationally.
REQ-019 Reset asserted in MEMWAIT or FLUSH SHALL abandon the pending operation.
  - No flush SHALL be issued after reset is released.

Verification
REQ-020 Load-use, fwd_en=1: exe_mem_r_en=1, exe_dest=5, id_src1=5 -> stall=1 in that cycle, stall_cnt +1.
  - Same stimulus with id_src1=0 -> stall=0.
REQ-021 No forwarding, fwd_en=0: mem_wb_en=1, mem_dest=7, id_two_src=1, id_src2=7 -> stall=1.
  - Same stimulus with id_two_src=0 -> stall=0.
REQ-022 Branch with hazard: branch_taken=1 and raw_haz=1 -> flush=1, stall=0 in cycle N; flush=1 in cycle N+1 (FLUSH); RUN at N+2.
REQ-023 Branch during memory wait: mem_busy=1 for 4 cycles with branch_taken pulsed in cycle 2 ->
  - superStall=1 for 4 cycles with flush=0;
  - then flush=1 for exactly 1 cycle.
REQ-024 Watchdog: mem_busy held 300 cycles -> wd_err rises after the 255th MEMWAIT cycle and stays 1 after mem_busy drops; stall_cnt=300.
REQ-025 Reset mid-wait: rst=0 during MEMWAIT with flush_pend=1 ->
  - all outputs 0, stall_cnt=0;
  - after release with idle inputs, flush stays 0.

Source files
------------

// File: rtl/hazard_if.sv
// hazard_if: pipeline-to-hazard-controller signal bundle.
//   master: pipeline side, drives register/stage info and reads control outputs.
//   slave : hazard controller side, reads stage info and drives stall/superStall/flush,
//           stall_cnt and wd_err.
interface hazard_if;
    logic        fwd_en;
    logic [4:0]  id_src1;
    logic [4:0]  id_src2;
    logic        id_two_src;
    logic [4:0]  exe_dest;
    logic        exe_wb_en;
    logic        exe_mem_r_en;
    logic [4:0]  mem_dest;
    logic        mem_wb_en;
    logic        branch_taken;
    logic        mem_busy;
    logic        stall;
    logic        superStall;
    logic        flush;
    logic [15:0] stall_cnt;
    logic        wd_err;
    modport master (
        output fwd_en, id_src1, id_src2, id_two_src, exe_dest, exe_wb_en, exe_mem_r_en,
               mem_dest, mem_wb_en, branch_taken, mem_busy,
        input  stall, superStall, flush, stall_cnt, wd_err
    );
    modport slave (
        input  fwd_en, id_src1, id_src2, id_two_src, exe_dest, exe_wb_en, exe_mem_r_en,
               mem_dest, mem_wb_en, branch_taken, mem_busy,
        output stall, superStall, flush, stall_cnt, wd_err
    );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: RAW/branch/memory-wait hazard controller with stall counter and memory watchdog.
//   clk : rising-edge clock.
//   rst : synchronous reset, active-low.
//   hz  : hazard_if.slave -- stage info in; stall, superStall, flush, stall_cnt, wd_err out.
module hazard_ctrl (
    input logic     clk,
    input logic     rst,
    hazard_if.slave hz
);
    localparam logic [1:0] RUN = 2'd0, MEMWAIT = 2'd1, FLUSH = 2'd2;
    logic [1:0]  state, state_nx;
    logic        flush_pend, flush_pend_nx;
    logic [7:0]  wd_cnt, wd_cnt_nx;
    logic [15:0] stall_cnt;
    logic        wd_err;
    logic        exe_match, mem_match, raw_haz;
    logic        stall_o, super_o, flush_o;
    assign exe_match = (hz.exe_dest != 5'd0) &&
                       (hz.id_src1 == hz.exe_dest || (hz.id_two_src && hz.id_src2 == hz.exe_dest));
    assign mem_match = (hz.mem_dest != 5'd0) &&
                       (hz.id_src1 == hz.mem_dest || (hz.id_two_src && hz.id_src2 == hz.mem_dest));
    assign raw_haz = hz.fwd_en ? (hz.exe_mem_r_en && exe_match)
                               : ((hz.exe_wb_en && exe_match) || (hz.mem_wb_en && mem_match));
    // superStall follows mem_busy in every state, so the cycle in which the memory
    // completes is already released; a pending branch flush follows in FLUSH.
    always_comb begin
        super_o       = 1'b0;
        flush_o       = 1'b0;
        stall_o       = 1'b0;
        state_nx      = state;
        flush_pend_nx = flush_pend;
        if (rst) begin
            case (state)
                RUN: begin
                    super_o       = hz.mem_busy;
                    flush_o       = hz.branch_taken && !hz.mem_busy;
                    stall_o       = raw_haz && !hz.branch_taken && !hz.mem_busy;
                    state_nx      = hz.mem_busy ? MEMWAIT : (hz.branch_taken ? FLUSH : RUN);
                    flush_pend_nx = hz.mem_busy && hz.branch_taken;
                end
                MEMWAIT: begin
                    super_o       = hz.mem_busy;
                    flush_pend_nx = flush_pend || hz.branch_taken;
                    state_nx      = hz.mem_busy ? MEMWAIT : (flush_pend_nx ? FLUSH : RUN);
                end
                FLUSH: begin
                    super_o       = hz.mem_busy;
                    flush_o       = !hz.mem_busy;
                    state_nx      = hz.mem_busy ? MEMWAIT : RUN;
                    flush_pend_nx = hz.mem_busy;
                end
                default: begin
                    state_nx      = RUN;
                    flush_pend_nx = 1'b0;
                end
            endcase
        end
    end
    assign wd_cnt_nx = (state == MEMWAIT && hz.mem_busy) ? (wd_cnt == 8'hFF ? wd_cnt : wd_cnt + 8'd1) : 8'd0;
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= RUN;
            flush_pend <= 1'b0;
            wd_cnt     <= 8'd0;
            stall_cnt  <= 16'd0;
            wd_err     <= 1'b0;
        end else begin
            state      <= state_nx;
            flush_pend <= flush_pend_nx;
            wd_cnt     <= wd_cnt_nx;
            stall_cnt  <= stall_cnt + 16'((stall_o || super_o) && stall_cnt != 16'hFFFF);
            wd_err     <= wd_err || wd_cnt_nx == 8'hFF;
        end
    end
    assign hz.stall      = stall_o;
    assign hz.superStall = super_o;
    assign hz.flush      = flush_o;
    assign hz.stall_cnt  = stall_cnt;
    assign hz.wd_err     = wd_err;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed and randomized checks of hazard_ctrl against a behavioural model.
module tb_hazard_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    hazard_if hif ();
    hazard_ctrl dut (.clk(clk), .rst(rst), .hz(hif.slave));
    always #5 clk = ~clk;
    // model: waiting on memory, branch flush owed after the wait, flush cycle in progress
    bit m_wait, m_owe, m_flushing, m_wd;
    int m_wait_len, m_cnt;
    bit e_stall, e_super, e_flush;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask
    function automatic bit hit(input logic [4:0] d);
        return d != 0 && (hif.id_src1 == d || (hif.id_two_src && hif.id_src2 == d));
    endfunction
    task automatic idle();
        hif.fwd_en = 0; hif.id_src1 = 0; hif.id_src2 = 0; hif.id_two_src = 0;
        hif.exe_dest = 0; hif.exe_wb_en = 0; hif.exe_mem_r_en = 0;
        hif.mem_dest = 0; hif.mem_wb_en = 0; hif.branch_taken = 0; hif.mem_busy = 0;
    endtask
    // compare against the model for the current cycle, then advance model and clock
    task automatic tick();
        bit raw, mb, bt;
        mb  = hif.mem_busy;
        bt  = hif.branch_taken;
        raw = hif.fwd_en ? (hif.exe_mem_r_en && hit(hif.exe_dest))
                         : ((hif.exe_wb_en && hit(hif.exe_dest)) || (hif.mem_wb_en && hit(hif.mem_dest)));
        e_super = rst && mb;
        e_flush = rst && !mb && (m_flushing || (!m_wait && bt));
        e_stall = rst && !m_wait && !m_flushing && raw && !bt && !mb;
        chk("m_super", hif.superStall, e_super);
        chk("m_flush", hif.flush, e_flush);
        chk("m_stall", hif.stall, e_stall);
        chk("m_cnt", hif.stall_cnt, m_cnt);
        chk("m_wd", hif.wd_err, m_wd);
        if (!rst) begin
            m_wait = 0; m_owe = 0; m_flushing = 0; m_wd = 0; m_wait_len = 0; m_cnt = 0;
        end else begin
            if ((e_stall || e_super) && m_cnt < 65535) m_cnt++;
            m_wait_len = (m_wait && mb) ? m_wait_len + 1 : 0;
            if (m_wait_len >= 255) m_wd = 1;
            if (mb) begin
                m_owe = m_owe || bt || m_flushing;
                m_wait = 1;
                m_flushing = 0;
            end else if (m_wait) begin
                m_flushing = m_owe || bt;
                m_wait = 0;
                m_owe = 0;
            end else if (m_flushing) m_flushing = 0;
            else m_flushing = bt;
        end
        @(posedge clk);
        #1;
    endtask
    initial begin
        int busy_left, nflush;
        bit prev_bt;
        idle();
        rst = 0;
        @(posedge clk); #1;
        #2; tick(); #2; tick();
        chk("rst_stall", hif.stall, 0);
        chk("rst_super", hif.superStall, 0);
        chk("rst_flush", hif.flush, 0);
        chk("rst_cnt", hif.stall_cnt, 0);
        chk("rst_wd", hif.wd_err, 0);
        rst = 1;
        hif.fwd_en = 1; hif.exe_mem_r_en = 1; hif.exe_dest = 5; hif.id_src1 = 5;
        #2 chk("lu_stall", hif.stall, 1);
        tick();
        chk("lu_cnt", hif.stall_cnt, 1);
        hif.id_src1 = 0;
        #2 chk("lu_r0", hif.stall, 0);
        tick();
        idle();
        hif.mem_wb_en = 1; hif.mem_dest = 7; hif.id_two_src = 1; hif.id_src2 = 7;
        #2 chk("nf_stall", hif.stall, 1);
        tick();
        hif.id_two_src = 0;
        #2 chk("nf_one_src", hif.stall, 0);
        tick();
        idle();
        hif.fwd_en = 1; hif.exe_mem_r_en = 1; hif.exe_dest = 3; hif.id_src1 = 3; hif.branch_taken = 1;
        #2 chk("br_flush_n", hif.flush, 1);
        chk("br_stall_n", hif.stall, 0);
        tick();
        hif.branch_taken = 0;
        #2 chk("br_flush_n1", hif.flush, 1);
        chk("br_stall_n1", hif.stall, 0);
        tick();
        #2 chk("br_run_flush", hif.flush, 0);
        chk("br_run_stall", hif.stall, 1);
        tick();
        idle();
        for (int i = 0; i < 4; i++) begin
            hif.mem_busy = 1; hif.branch_taken = (i == 1);
            #2 chk("mw_super", hif.superStall, 1);
            chk("mw_flush", hif.flush, 0);
            tick();
        end
        idle();
        nflush = 0;
        for (int i = 0; i < 4; i++) begin
            #2 nflush += int'(hif.flush);
            chk("mw_after_super", hif.superStall, 0);
            tick();
        end
        chk("mw_flush_count", nflush, 1);
        rst = 0; #2 tick(); rst = 1;
        hif.mem_busy = 1;
        for (int i = 1; i <= 300; i++) begin
            #2;
            if (i == 256) chk("wd_before", hif.wd_err, 0);
            if (i == 257) chk("wd_rise", hif.wd_err, 1);
            tick();
        end
        hif.mem_busy = 0;
        #2 chk("wd_exit_super", hif.superStall, 0);
        chk("wd_cnt300", hif.stall_cnt, 300);
        tick();
        chk("wd_sticky", hif.wd_err, 1);
        hif.mem_busy = 1; hif.branch_taken = 1;
        #2 tick();
        hif.branch_taken = 0;
        #2 tick();
        rst = 0;
        #2 chk("rw_super", hif.superStall, 0);
        chk("rw_flush", hif.flush, 0);
        chk("rw_stall", hif.stall, 0);
        tick();
        chk("rw_cnt", hif.stall_cnt, 0);
        chk("rw_wd", hif.wd_err, 0);
        rst = 1;
        idle();
        for (int i = 0; i < 3; i++) begin
            #2 chk("rw_no_flush", hif.flush, 0);
            tick();
        end
        busy_left = 0;
        prev_bt = 0;
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 149) != 0);
            hif.fwd_en = 1'($urandom);
            hif.id_src1 = 5'($urandom_range(0, 7));
            hif.id_src2 = 5'($urandom_range(0, 7));
            hif.id_two_src = 1'($urandom);
            hif.exe_dest = 5'($urandom_range(0, 7));
            hif.exe_wb_en = 1'($urandom);
            hif.exe_mem_r_en = 1'($urandom);
            hif.mem_dest = 5'($urandom_range(0, 7));
            hif.mem_wb_en = 1'($urandom);
            if (busy_left == 0 && $urandom_range(0, 11) == 0) busy_left = $urandom_range(1, 6);
            hif.mem_busy = (busy_left > 0);
            if (busy_left > 0) busy_left--;
            hif.branch_taken = !prev_bt && $urandom_range(0, 7) == 0;
            prev_bt = hif.branch_taken;
            #2 tick();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
